apb_fll_if_multi: RTL and testbench
===================================

Name: apb_fll_if_multi

Overview:
Parametrised APB slave bridging a single APB port to NB_FLL FLL configuration ports. Each FLL uses a 4-phase req/ack handshake that crosses into the FLL clock domain. Adds over the 3-FLL bridge:
- registered, stable request/address/data outputs
- per-FLL lock synchronisers with sticky lock-lost bits and an interrupt
Sits on the SoC peripheral APB bus next to the clock-generation subsystem.

Parameters:
APB_ADDR_WIDTH, 12, APB address width. Must be >= clog2(4*NB_FLL+2)+2.
NB_FLL, 3, number of FLLs, 1..16.
TIMEOUT_CYCLES, 1024, HCLK cycles allowed per handshake phase before abort. Only used with APB_FLL_TIMEOUT_EN.

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous reset, active-high
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  32  APB write data
PWRITE  in  1  APB write
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data
PREADY  out  1  APB ready
PSLVERR  out  1  APB error
fll_req  out  NB_FLL  per-FLL request
fll_wrn  out  NB_FLL  per-FLL write-not (1 = read)
fll_add  out  2*NB_FLL  per-FLL register address; FLL i at [2i+1:2i]
fll_data  out  32*NB_FLL  per-FLL write data; FLL i at [32i+31:32i]
fll_ack  in  NB_FLL  per-FLL ack, asynchronous
fll_r_data  in  32*NB_FLL  per-FLL read data; valid while ack high
fll_lock  in  NB_FLL  per-FLL lock, asynchronous
lock_irq  out  1  OR of sticky lock-lost bits

Behaviour:
- Reset is asynchronous and active-high on HRESET. All flops clear; state = IDLE; fll_req=0; fll_wrn=all 1; fll_add=0; fll_data=0; lock_irq=0; PSLVERR=0.
- Access phase = PSEL & PENABLE. Word index W = PADDR[APB_ADDR_WIDTH-1:2]; PADDR[1:0] ignored.
- Address map:
  - W < 4*NB_FLL: FLL i = W/4, register W%4.
  - W = 4*NB_FLL: STATUS (RO). [NB_FLL-1:0] = synced lock.
  - W = 4*NB_FLL+1: LOST (RW1C). [NB_FLL-1:0] = sticky lock-lost.
  - Any other W: PREADY=1 combinationally; reads return 0; writes are ignored.
- STATUS/LOST access: PREADY=1 in the same cycle (zero wait). LOST write clears bits where PWDATA=1. A set and a clear of the same bit in the same cycle: set wins.
- Lock path: 2-flop sync per fll_lock. A 1->0 transition of the synced lock sets LOST[i]. lock_irq = |LOST (registered).
- Ack path: 2-flop sync per fll_ack (ack_s).
- FSM states: IDLE, REQ, RESP, DRAIN.
  - IDLE: on FLL access, capture i, W%4, PWDATA, ~PWRITE into regs -> REQ. PREADY=0.
  - REQ: fll_req[i]=1 (registered, asserted from the cycle after capture). When ack_s[i]=1: capture fll_r_data[i] into rdata_q, drop req -> RESP.
  - RESP: PREADY=1 for exactly one cycle; PRDATA=rdata_q for reads, 0 for writes -> DRAIN.
  - DRAIN: wait for ack_s[i]=0 -> IDLE. New APB accesses stall with PREADY=0 until IDLE.
- Latency: at least 3 cycles of ack sync + FLL response before PREADY.
- fll_wrn[i], fll_add[i], fll_data[i] are driven from the capture regs from REQ through DRAIN and stay stable for the whole handshake. Unselected channels hold their reset values.
- Only one FLL transaction is outstanding at a time. The FSM ignores acks on unselected channels.
- HRESET asserted mid-handshake: req drops immediately; FSM returns to IDLE. An FLL still holding ack is tolerated: the next request to that FLL waits in REQ and ignores the stale ack until ack_s has been seen low.
- PSLVERR=0 unless the timeout feature fires.

Optional Feature:
Macro APB_FLL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and to DRAIN.
  - Expiry in REQ (TIMEOUT_CYCLES with no ack): drop req -> RESP with PSLVERR=1, PRDATA=0.
  - Expiry in DRAIN: force IDLE.
- Undefined: no counter; REQ and DRAIN wait indefinitely; PSLVERR tied to 0.

Test Plan:
- NB_FLL=4, write 0x1234_5678 to W=6. Required: fll_req[1]=1, fll_add[3:2]=2, fll_wrn[1]=0, fll_data[63:32]=0x1234_5678. FLL model acks after 5 cycles. PREADY pulses once; next access only after ack low.
- Read W=13, fll_r_data[3]=0xCAFE_F00D. Required: PRDATA=0xCAFE_F00D in the PREADY cycle; fll_wrn[3]=1.
- fll_lock=4'b1111, then bit2 drops. Required: STATUS reads 4'b1011; LOST reads 4'b0100; lock_irq=1. Write LOST 0x4 -> reads 0; lock_irq=0.
- Read W=0x3F (unmapped). Required: PREADY=1 in the first access cycle; PRDATA=0.
- Assert HRESET during REQ on FLL0 while ack is high. Required: fll_req=0 immediately. The following request waits for ack low then high before completing.
- APB_FLL_TIMEOUT_EN, TIMEOUT_CYCLES=16, FLL never acks. Required: PREADY=1 with PSLVERR=1 about 17 cycles after REQ entry; req drops.

Source files
------------

// File: rtl/apb_fll_if_multi.sv
// apb_fll_if_multi: APB slave fanning out to NB_FLL FLL configuration ports.
// Each FLL access runs a 4-phase req/ack handshake into the FLL clock domain.
// Lock inputs are synchronised; falling locks set sticky LOST bits that drive lock_irq.
// Optional build macro APB_FLL_TIMEOUT_EN adds a per-phase handshake timeout
// that completes the APB transfer with PSLVERR=1.
module apb_fll_if_multi #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_FLL         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]              PWDATA,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NB_FLL-1:0]        fll_req,
  output logic [NB_FLL-1:0]        fll_wrn,
  output logic [2*NB_FLL-1:0]      fll_add,
  output logic [32*NB_FLL-1:0]     fll_data,
  input  logic [NB_FLL-1:0]        fll_ack,
  input  logic [32*NB_FLL-1:0]     fll_r_data,
  input  logic [NB_FLL-1:0]        fll_lock,
  output logic                     lock_irq
);

  localparam int WW    = APB_ADDR_WIDTH - 2;
  localparam int IDX_W = (NB_FLL > 1) ? $clog2(NB_FLL) : 1;
  localparam logic [WW-1:0] W_STATUS = WW'(4 * NB_FLL);
  localparam logic [WW-1:0] W_LOST   = WW'(4 * NB_FLL + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [1:0]  add_q, add_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wrn_q, wrn_d;
  logic [31:0] rdata_q, rdata_d;
  logic        seen_low_q, seen_low_d;  // ack_s seen low since entering REQ
  logic        err_q, err_d;
  logic [NB_FLL-1:0]    fll_req_q, fll_req_d, fll_wrn_q, fll_wrn_d;
  logic [2*NB_FLL-1:0]  fll_add_q, fll_add_d;
  logic [32*NB_FLL-1:0] fll_data_q, fll_data_d;
  logic [NB_FLL-1:0] ack_s1_q, ack_s2_q, lock_s1_q, lock_s2_q, lock_prev_q;
  logic [NB_FLL-1:0] lost_q, lost_d;
  logic        lock_irq_q, lock_irq_d;

  logic [WW-1:0]    word;
  logic [IDX_W-1:0] idx;
  logic             access, fll_hit, ack_sel, expired;
  logic [31:0]      rdata_sel;
  logic             unused_paddr;

  assign word         = PADDR[APB_ADDR_WIDTH-1:2];
  assign idx          = IDX_W'(word >> 2);
  assign access       = PSEL & PENABLE;
  assign fll_hit      = (word < W_STATUS);
  assign unused_paddr = ^PADDR[1:0];

`ifdef APB_FLL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Phase counter: restarts on entry to REQ or DRAIN, counts while staying there
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == REQ) || (state_q == DRAIN)))
      cnt_d = cnt_q + 1'b1;
  end

  // Phase counter register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  // Select the ack and read data of the channel owning the current transaction
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NB_FLL; i++) begin
      if (sel_q == IDX_W'(i)) begin
        ack_sel   = ack_s2_q[i];
        rdata_sel = fll_r_data[32*i +: 32];
      end
    end
  end

  // Handshake FSM next state and capture registers
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    add_d      = add_q;
    wdata_d    = wdata_q;
    wrn_d      = wrn_q;
    rdata_d    = rdata_q;
    seen_low_d = seen_low_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (access && fll_hit) begin
          sel_d      = idx;
          add_d      = word[1:0];
          wdata_d    = PWDATA;
          wrn_d      = ~PWRITE;
          rdata_d    = '0;
          err_d      = 1'b0;
          seen_low_d = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // A stale ack left over from an aborted handshake is ignored until it goes low
        seen_low_d = seen_low_q | ~ack_sel;
        if (seen_low_q && ack_sel) begin
          rdata_d = wrn_q ? rdata_sel : 32'h0;
          state_d = RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = DRAIN;
      default: if (!ack_sel || expired) state_d = IDLE;
    endcase
  end

  // FLL port values for the next cycle: only the owning channel leaves reset values
  always_comb begin
    fll_req_d  = '0;
    fll_wrn_d  = '1;
    fll_add_d  = '0;
    fll_data_d = '0;
    if (state_d != IDLE) begin
      for (int i = 0; i < NB_FLL; i++) begin
        if (sel_d == IDX_W'(i)) begin
          fll_req_d[i]          = (state_d == REQ);
          fll_wrn_d[i]          = wrn_d;
          fll_add_d[2*i +: 2]   = add_d;
          fll_data_d[32*i +: 32] = wdata_d;
        end
      end
    end
  end

  // FSM state, capture registers and registered FLL outputs
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      add_q      <= '0;
      wdata_q    <= '0;
      wrn_q      <= 1'b1;
      rdata_q    <= '0;
      seen_low_q <= 1'b0;
      err_q      <= 1'b0;
      fll_req_q  <= '0;
      fll_wrn_q  <= '1;
      fll_add_q  <= '0;
      fll_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      add_q      <= add_d;
      wdata_q    <= wdata_d;
      wrn_q      <= wrn_d;
      rdata_q    <= rdata_d;
      seen_low_q <= seen_low_d;
      err_q      <= err_d;
      fll_req_q  <= fll_req_d;
      fll_wrn_q  <= fll_wrn_d;
      fll_add_q  <= fll_add_d;
      fll_data_q <= fll_data_d;
    end
  end

  // Sticky lock-lost bits: clear by write-1, a simultaneous lock loss wins
  always_comb begin
    lost_d = lost_q;
    if ((state_q == IDLE) && access && PWRITE && (word == W_LOST))
      lost_d = lost_d & ~PWDATA[NB_FLL-1:0];
    lost_d     = lost_d | (lock_prev_q & ~lock_s2_q);
    lock_irq_d = |lost_d;
  end

  // Ack/lock synchronisers, lock edge history, LOST and interrupt registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ack_s1_q    <= '0;
      ack_s2_q    <= '0;
      lock_s1_q   <= '0;
      lock_s2_q   <= '0;
      lock_prev_q <= '0;
      lost_q      <= '0;
      lock_irq_q  <= 1'b0;
    end else begin
      ack_s1_q    <= fll_ack;
      ack_s2_q    <= ack_s1_q;
      lock_s1_q   <= fll_lock;
      lock_s2_q   <= lock_s1_q;
      lock_prev_q <= lock_s2_q;
      lost_q      <= lost_d;
      lock_irq_q  <= lock_irq_d;
    end
  end

  // APB response: FLL completions in RESP, local/unmapped words with zero wait in IDLE
  always_comb begin
    PREADY = 1'b0;
    PRDATA = '0;
    if (state_q == RESP) begin
      PREADY = 1'b1;
      PRDATA = rdata_q;
    end else if ((state_q == IDLE) && access && !fll_hit) begin
      PREADY = 1'b1;
      if (!PWRITE) begin
        if (word == W_STATUS)    PRDATA = 32'(lock_s2_q);
        else if (word == W_LOST) PRDATA = 32'(lost_q);
      end
    end
  end

  assign PSLVERR  = (state_q == RESP) & err_q;
  assign fll_req  = fll_req_q;
  assign fll_wrn  = fll_wrn_q;
  assign fll_add  = fll_add_q;
  assign fll_data = fll_data_q;
  assign lock_irq = lock_irq_q;

endmodule

// File: tb/tb_apb_fll_if_multi.sv
// Directed bench for apb_fll_if_multi with NB_FLL=4 and a behavioural FLL responder.
module tb_apb_fll_if_multi;
  logic         clk = 1'b0;
  logic         HRESET;
  logic [11:0]  PADDR;
  logic [31:0]  PWDATA;
  logic         PWRITE, PSEL, PENABLE;
  logic [31:0]  PRDATA;
  logic         PREADY, PSLVERR;
  logic [3:0]   fll_req, fll_wrn, fll_ack, fll_lock;
  logic [7:0]   fll_add;
  logic [127:0] fll_data, fll_r_data;
  logic         lock_irq;

  int n_vec = 0;
  int n_err = 0;
  bit model_en = 1'b0;
  logic [31:0] mdl_rdata [4];

  always #5 clk = ~clk;

  apb_fll_if_multi #(.APB_ADDR_WIDTH(12), .NB_FLL(4), .TIMEOUT_CYCLES(16)) dut (
    .HCLK(clk), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .fll_req(fll_req), .fll_wrn(fll_wrn), .fll_add(fll_add), .fll_data(fll_data),
    .fll_ack(fll_ack), .fll_r_data(fll_r_data), .fll_lock(fll_lock), .lock_irq(lock_irq)
  );

  // FLL responder: acks 5 cycles after req, holds ack 4 cycles after req drops
  initial begin : fll_model
    int ch;
    fll_ack = '0;
    fll_r_data = '0;
    forever begin
      @(posedge clk); #1;
      if (model_en && (fll_req != 4'b0)) begin
        ch = 0;
        for (int i = 0; i < 4; i++) if (fll_req[i]) ch = i;
        repeat (5) @(posedge clk);
        #1;
        fll_r_data[32*ch +: 32] = mdl_rdata[ch];
        fll_ack[ch] = 1'b1;
        while (fll_req[ch]) begin @(posedge clk); #1; end
        repeat (4) @(posedge clk);
        #1;
        fll_ack[ch] = 1'b0;
      end
    end
  end

  task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits, output bit ok);
    @(posedge clk); #1;
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0; ok = 1'b0; rd = '0; err = 1'b0;
    while (waits < 200) begin
      @(negedge clk);
      if (PREADY) begin rd = PRDATA; err = PSLVERR; ok = 1'b1; break; end
      waits++;
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_req(input int ch, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (fll_req[ch]) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL wait_req%0d: req never asserted, required within 100 cycles", ch);
    end
  endtask

  task automatic wait_ready(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (PREADY) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL wait_ready: PREADY never asserted, required within 100 cycles");
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    fll_lock = 4'hF;
    mdl_rdata[0] = 32'h0BAD_BEEF; mdl_rdata[1] = 32'h1111_2222;
    mdl_rdata[2] = 32'h3333_4444; mdl_rdata[3] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (fll_req !== 4'h0) begin n_err++; $display("FAIL rst_req: got %h required 0", fll_req); end
    n_vec++; if (fll_wrn !== 4'hF) begin n_err++; $display("FAIL rst_wrn: got %h required f", fll_wrn); end
    n_vec++; if (fll_add !== 8'h00) begin n_err++; $display("FAIL rst_add: got %h required 00", fll_add); end
    n_vec++; if (fll_data !== 128'h0) begin n_err++; $display("FAIL rst_data: got %h required 0", fll_data); end
    n_vec++; if ({lock_irq, PSLVERR, PREADY} !== 3'b000) begin
      n_err++; $display("FAIL rst_flags: irq/slverr/ready got %b required 000", {lock_irq, PSLVERR, PREADY});
    end
    @(posedge clk); #1;
    HRESET = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write_fll1();
    logic [31:0] rd, rd2; logic err, err2; int waits, waits2; bit ok, ok2, seen, rdy;
    model_en = 1'b1;
    fork
      apb_xfer(12'h018, 1'b1, 32'h1234_5678, rd, err, waits, ok);
      begin
        wait_req(1, seen);
        if (seen) begin
          n_vec++; if (fll_req !== 4'b0010) begin n_err++; $display("FAIL wr_req: got %b required 0010", fll_req); end
          n_vec++; if (fll_wrn !== 4'b1101) begin n_err++; $display("FAIL wr_wrn: got %b required 1101", fll_wrn); end
          n_vec++; if (fll_add !== 8'h08) begin n_err++; $display("FAIL wr_add: got %h required 08", fll_add); end
          n_vec++; if (fll_data !== {64'h0, 32'h1234_5678, 32'h0}) begin
            n_err++; $display("FAIL wr_data: got %h required 0..0_12345678_00000000", fll_data);
          end
          wait_ready(rdy);
          if (rdy) begin
            n_vec++; if (fll_req !== 4'b0000) begin n_err++; $display("FAIL wr_req_drop: got %b required 0000", fll_req); end
          end
        end
      end
    join
    n_vec++; if (!ok || err !== 1'b0 || rd !== 32'h0) begin
      n_err++; $display("FAIL wr_resp: ok=%0d err=%b prdata=%h required ok=1 err=0 prdata=0", ok, err, rd);
    end
    apb_xfer(12'h040, 1'b0, 32'h0, rd2, err2, waits2, ok2);
    n_vec++; if (!ok2 || waits2 < 1) begin
      n_err++; $display("FAIL wr_stall: ok=%0d waits=%0d required ok=1 waits>=1", ok2, waits2);
    end
    n_vec++; if (fll_ack[1] !== 1'b0) begin n_err++; $display("FAIL wr_ack_low: got %b required 0", fll_ack[1]); end
    n_vec++; if (rd2 !== 32'h0000_000F) begin n_err++; $display("FAIL wr_status: got %h required 0000000f", rd2); end
  endtask

  task automatic test_read(input logic [11:0] addr, input int ch, input logic [3:0] exp_wrn,
                           input logic [7:0] exp_add, input logic [31:0] exp_rd);
    logic [31:0] rd; logic err; int waits; bit ok, seen;
    model_en = 1'b1;
    fork
      apb_xfer(addr, 1'b0, 32'hFFFF_FFFF, rd, err, waits, ok);
      begin
        wait_req(ch, seen);
        if (seen) begin
          n_vec++; if (fll_wrn !== exp_wrn || fll_add !== exp_add) begin
            n_err++; $display("FAIL rd_ctl%0d: wrn=%b add=%h required wrn=%b add=%h", ch, fll_wrn, fll_add, exp_wrn, exp_add);
          end
        end
      end
    join
    n_vec++; if (!ok || rd !== exp_rd || waits < 3) begin
      n_err++; $display("FAIL rd_data%0d: ok=%0d prdata=%h waits=%0d required prdata=%h waits>=3", ch, ok, rd, waits, exp_rd);
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic test_lock();
    logic [31:0] rd; logic err; int waits; bit ok;
    apb_xfer(12'h044, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL lost_init: got %h required 0", rd); end
    @(posedge clk); #1; fll_lock = 4'b1011;
    repeat (5) @(posedge clk);
    apb_xfer(12'h040, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (!ok || waits != 0 || rd !== 32'hB) begin
      n_err++; $display("FAIL status: got %h waits=%0d required 0000000b waits=0", rd, waits);
    end
    apb_xfer(12'h044, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (rd !== 32'h4) begin n_err++; $display("FAIL lost_set: got %h required 00000004", rd); end
    n_vec++; if (lock_irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b required 1", lock_irq); end
    apb_xfer(12'h044, 1'b1, 32'h0, rd, err, waits, ok);
    apb_xfer(12'h044, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (rd !== 32'h4) begin n_err++; $display("FAIL lost_w0: got %h required 00000004", rd); end
    apb_xfer(12'h044, 1'b1, 32'h4, rd, err, waits, ok);
    apb_xfer(12'h044, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL lost_clr: got %h required 0", rd); end
    n_vec++; if (lock_irq !== 1'b0) begin n_err++; $display("FAIL irq_clr: got %b required 0", lock_irq); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic err; int waits; bit ok;
    apb_xfer(12'h0FC, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (!ok || waits != 0 || rd !== 32'h0) begin
      n_err++; $display("FAIL unmap_3f: prdata=%h waits=%0d required 0 waits=0", rd, waits);
    end
    apb_xfer(12'h048, 1'b1, 32'hFFFF_FFFF, rd, err, waits, ok);
    n_vec++; if (!ok || waits != 0 || fll_req !== 4'h0) begin
      n_err++; $display("FAIL unmap_wr: waits=%0d req=%b required waits=0 req=0000", waits, fll_req);
    end
    apb_xfer(12'h048, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (!ok || waits != 0 || rd !== 32'h0) begin
      n_err++; $display("FAIL unmap_12: prdata=%h waits=%0d required 0 waits=0", rd, waits);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int waits; bit ok, seen, early;
    model_en = 1'b0;
    @(posedge clk); #1;
    PADDR = 12'h000; PWRITE = 1'b1; PWDATA = 32'h55; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1; PENABLE = 1'b1;
    wait_req(0, seen);
    @(posedge clk); #1; fll_ack[0] = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (fll_req !== 4'b0001) begin n_err++; $display("FAIL mid_req_on: got %b required 0001", fll_req); end
    HRESET = 1'b1;
    #1;
    n_vec++; if (fll_req !== 4'b0000 || PREADY !== 1'b0) begin
      n_err++; $display("FAIL mid_req_drop: req=%b ready=%b required req=0000 ready=0", fll_req, PREADY);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1; HRESET = 1'b0;
    repeat (4) @(posedge clk);
    early = 1'b0;
    fork
      apb_xfer(12'h000, 1'b1, 32'hA5A5_0001, rd, err, waits, ok);
      begin
        wait_req(0, seen);
        repeat (8) begin @(negedge clk); if (PREADY || !fll_req[0]) early = 1'b1; end
        @(posedge clk); #1; fll_ack[0] = 1'b0;
        repeat (4) begin @(negedge clk); if (PREADY) early = 1'b1; end
        @(posedge clk); #1; fll_ack[0] = 1'b1;
        for (int n = 0; n < 50 && fll_req[0]; n++) @(posedge clk);
        #1; fll_ack[0] = 1'b0;
      end
    join
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL stale_ack: early completion=%b required 0", early); end
    n_vec++; if (!ok || err !== 1'b0) begin
      n_err++; $display("FAIL after_rst: ok=%0d err=%b required ok=1 err=0", ok, err);
    end
    repeat (8) @(posedge clk);
  endtask

`ifdef APB_FLL_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic err; int waits; bit ok;
    model_en = 1'b0;
    apb_xfer(12'h014, 1'b0, 32'h0, rd, err, waits, ok);
    n_vec++; if (!ok || err !== 1'b1 || rd !== 32'h0 || waits < 15 || waits > 19) begin
      n_err++; $display("FAIL timeout: ok=%0d err=%b prdata=%h waits=%0d required err=1 prdata=0 waits 15..19", ok, err, rd, waits);
    end
    n_vec++; if (fll_req !== 4'h0) begin n_err++; $display("FAIL timeout_req: got %b required 0000", fll_req); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_fll1();
    test_read(12'h034, 3, 4'b1111, 8'h40, 32'hCAFE_F00D);
    test_read(12'h00C, 0, 4'b1111, 8'h03, 32'h0BAD_BEEF);
    test_lock();
    test_unmapped();
    test_reset_mid();
`ifdef APB_FLL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
